// File: rtl/gcn_phase_sequencer.sv
// Phase controller for one GCN layer: kicks the transformation block, waits for
// it under a watchdog, then streams FM*WM row indices to the aggregator and
// steers the shared input-memory read port to whichever phase owns it.
module gcn_phase_sequencer #(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned ROW_W          = 3,
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              trans_start,
    input  logic              trans_done,
    input  logic              trans_enable_read,
    input  logic [ADDR_W-1:0] trans_read_addr,
    input  logic              agg_enable_read,
    input  logic [ADDR_W-1:0] agg_read_addr,
    output logic [ROW_W-1:0]  read_row,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              mem_enable_read,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Counter wide enough to hold TIMEOUT_CYCLES-1 even when TIMEOUT_CYCLES is 1.
    localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_TRANS_START = 3'd1,
        S_TRANS_WAIT  = 3'd2,
        S_AGG         = 3'd3,
        S_DONE        = 3'd4,
        S_ERROR       = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    // State, row index and watchdog registers; reset aborts straight to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state logic; the watchdog only runs in TRANS_WAIT and is zero elsewhere.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        wd_d    = '0;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) state_d = S_TRANS_START;
            end
            S_TRANS_START: begin
                state_d = S_TRANS_WAIT;
            end
            S_TRANS_WAIT: begin
                // A done arriving on the timeout cycle still counts as success.
                if (trans_done) begin
                    state_d = S_AGG;
                    row_d   = '0;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_AGG: begin
                if (row_ready) begin
                    if (row_q == ROW_W'(FEATURE_ROWS - 1)) begin
                        state_d = S_DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                row_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the state register, plus the memory port steering.
    always_comb begin
        trans_start     = 1'b0;
        row_valid       = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        mem_enable_read = 1'b0;
        mem_read_addr   = '0;
        read_row        = row_q;
        case (state_q)
            S_TRANS_START: begin
                trans_start     = 1'b1;
                busy            = 1'b1;
                mem_enable_read = trans_enable_read;
                mem_read_addr   = trans_read_addr;
            end
            S_TRANS_WAIT: begin
                busy            = 1'b1;
                mem_enable_read = trans_enable_read;
                mem_read_addr   = trans_read_addr;
            end
            S_AGG: begin
                row_valid       = 1'b1;
                busy            = 1'b1;
                mem_enable_read = agg_enable_read;
                mem_read_addr   = agg_read_addr;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_gcn_phase_sequencer.sv
// Directed bench for gcn_phase_sequencer: a default instance for the layer flow
// and a short-timeout instance for the watchdog.
module tb_gcn_phase_sequencer;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned ROW_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, trans_done, row_ready;
    logic              trans_en, agg_en;
    logic [ADDR_W-1:0] trans_addr, agg_addr;
    logic              start2, trans_done2;

    logic              trans_start, row_valid, mem_en, busy, done, error;
    logic [ROW_W-1:0]  read_row;
    logic [ADDR_W-1:0] mem_addr;

    logic              trans_start2, row_valid2, mem_en2, busy2, done2, error2;
    logic [ROW_W-1:0]  read_row2;
    logic [ADDR_W-1:0] mem_addr2;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    gcn_phase_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .trans_start(trans_start),
        .trans_done(trans_done), .trans_enable_read(trans_en), .trans_read_addr(trans_addr),
        .agg_enable_read(agg_en), .agg_read_addr(agg_addr), .read_row(read_row),
        .row_valid(row_valid), .row_ready(row_ready), .mem_enable_read(mem_en),
        .mem_read_addr(mem_addr), .busy(busy), .done(done), .error(error)
    );

    gcn_phase_sequencer #(.TIMEOUT_CYCLES(16)) dut_wd (
        .clk(clk), .reset(reset), .start(start2), .trans_start(trans_start2),
        .trans_done(trans_done2), .trans_enable_read(trans_en), .trans_read_addr(trans_addr),
        .agg_enable_read(agg_en), .agg_read_addr(agg_addr), .read_row(read_row2),
        .row_valid(row_valid2), .row_ready(row_ready), .mem_enable_read(mem_en2),
        .mem_read_addr(mem_addr2), .busy(busy2), .done(done2), .error(error2)
    );

    // One clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // IDLE -> TRANS_START -> TRANS_WAIT -> AGG with a one-cycle trans_done.
    task automatic go_to_agg();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        trans_done = 1'b1; tick(); trans_done = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({trans_start, row_valid, read_row, mem_en, mem_addr, busy, done, error} !== '0) begin
            $display("FAIL reset_outputs: got %0h expected 0",
                     {trans_start, row_valid, read_row, mem_en, mem_addr, busy, done, error});
        end else passes++;
        @(negedge clk); reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) $display("FAIL reset_release: busy=%b error=%b expected 0 0", busy, error);
        else passes++;
    endtask

    task automatic test_basic_layer();
        int pulses = 0;
        row_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (trans_start !== 1'b1 || busy !== 1'b1) $display("FAIL trans_start_pulse: ts=%b busy=%b expected 1 1", trans_start, busy);
        else passes++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (trans_start) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL trans_start_single: extra pulses=%0d expected 0", pulses);
        else passes++;
        trans_done = 1'b1; tick(); trans_done = 1'b0;
        for (int r = 0; r < 6; r++) begin
            checks++;
            if (row_valid !== 1'b1 || read_row !== ROW_W'(r) || done !== 1'b0)
                $display("FAIL stream_row%0d: valid=%b row=%0d done=%b expected 1 %0d 0", r, row_valid, read_row, done, r);
            else passes++;
            tick();
        end
        checks++;
        if (done !== 1'b1 || row_valid !== 1'b0 || read_row !== '0)
            $display("FAIL done_pulse: done=%b valid=%b row=%0d expected 1 0 0", done, row_valid, read_row);
        else passes++;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_single: done=%b busy=%b expected 0 0", done, busy);
        else passes++;
    endtask

    task automatic test_ready_pattern();
        int exp_row = 0;
        int accepts = 0;
        int c = 0;
        int bad = 0;
        row_ready = 1'b0;
        go_to_agg();
        while (accepts < 6 && c < 40) begin
            row_ready = (c % 3 == 0);
            if (row_valid !== 1'b1 || read_row !== ROW_W'(exp_row)) bad++;
            tick();
            if (row_ready) begin
                exp_row++;
                accepts++;
            end
            c++;
        end
        row_ready = 1'b0;
        checks++;
        if (bad !== 0 || accepts !== 6) $display("FAIL ready_hold: bad_cycles=%0d accepts=%0d expected 0 6", bad, accepts);
        else passes++;
        checks++;
        if (c !== 16) $display("FAIL ready_cycles: cycles=%0d expected 16", c);
        else passes++;
        checks++;
        if (done !== 1'b1) $display("FAIL ready_done: done=%b expected 1", done);
        else passes++;
        tick();
    endtask

    task automatic test_watchdog();
        start2 = 1'b1; tick(); start2 = 1'b0;
        checks++;
        if (trans_start2 !== 1'b1) $display("FAIL wd_trans_start: ts=%b expected 1", trans_start2);
        else passes++;
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (error2 !== 1'b0 || busy2 !== 1'b1) $display("FAIL wd_early: error=%b busy=%b expected 0 1", error2, busy2);
        else passes++;
        tick();
        checks++;
        if (error2 !== 1'b1 || busy2 !== 1'b0) $display("FAIL wd_timeout: error=%b busy=%b expected 1 0", error2, busy2);
        else passes++;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (error2 !== 1'b1) $display("FAIL wd_sticky: error=%b expected 1", error2);
        else passes++;
        start2 = 1'b1; tick(); start2 = 1'b0;
        checks++;
        if (error2 !== 1'b0 || trans_start2 !== 1'b1) $display("FAIL wd_restart: error=%b ts=%b expected 0 1", error2, trans_start2);
        else passes++;
    endtask

    task automatic test_mem_mux();
        trans_addr = 13'h200; agg_addr = 13'h003;
        trans_en = 1'b1; agg_en = 1'b1;
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== '0) $display("FAIL mux_idle: en=%b addr=%0h expected 0 0", mem_en, mem_addr);
        else passes++;
        start = 1'b1; tick(); start = 1'b0;
        agg_en = 1'b0;
        tick();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 13'h200) $display("FAIL mux_trans: en=%b addr=%0h expected 1 200", mem_en, mem_addr);
        else passes++;
        trans_done = 1'b1; tick(); trans_done = 1'b0;
        trans_en = 1'b0; agg_en = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 13'h003) $display("FAIL mux_agg: en=%b addr=%0h expected 1 3", mem_en, mem_addr);
        else passes++;
        row_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        row_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || mem_en !== 1'b0 || mem_addr !== '0)
            $display("FAIL mux_done: done=%b en=%b addr=%0h expected 1 0 0", done, mem_en, mem_addr);
        else passes++;
        tick();
        trans_en = 1'b0; agg_en = 1'b0;
    endtask

    task automatic test_start_ignored();
        int ts_cnt = 0;
        int done_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        if (trans_start) ts_cnt++;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            if (trans_start) ts_cnt++;
        end
        start = 1'b0;
        trans_done = 1'b1; tick(); trans_done = 1'b0;
        row_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            start = (i == 2);
            tick();
            if (trans_start) ts_cnt++;
            if (done) done_cnt++;
            if (i >= 5) row_ready = 1'b0;
        end
        start = 1'b0; row_ready = 1'b0;
        checks++;
        if (ts_cnt !== 1 || done_cnt !== 1) $display("FAIL start_ignored: trans_start=%0d done=%0d expected 1 1", ts_cnt, done_cnt);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL start_ignored_idle: busy=%b expected 0", busy);
        else passes++;
    endtask

    task automatic test_reset_mid();
        agg_en = 1'b1; agg_addr = 13'h003;
        row_ready = 1'b0;
        go_to_agg();
        row_ready = 1'b1; tick(); row_ready = 1'b0;
        checks++;
        if (row_valid !== 1'b1 || read_row !== ROW_W'(1)) $display("FAIL mid_setup: valid=%b row=%0d expected 1 1", row_valid, read_row);
        else passes++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({trans_start, row_valid, read_row, mem_en, mem_addr, busy, done, error} !== '0) begin
            $display("FAIL mid_reset_outputs: got %0h expected 0",
                     {trans_start, row_valid, read_row, mem_en, mem_addr, busy, done, error});
        end else passes++;
        tick();
        @(negedge clk); reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || row_valid !== 1'b0 || read_row !== '0 || done !== 1'b0)
            $display("FAIL mid_reset_release: busy=%b valid=%b row=%0d done=%b expected 0 0 0 0", busy, row_valid, read_row, done);
        else passes++;
        agg_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; trans_done = 1'b0; row_ready = 1'b0;
        trans_en = 1'b0; agg_en = 1'b0; trans_addr = '0; agg_addr = '0;
        start2 = 1'b0; trans_done2 = 1'b0;
        tick(); tick();
        test_reset();
        test_basic_layer();
        test_ready_pattern();
        test_watchdog();
        test_mem_mux();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule
